// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared types and constants for the serial add/subtract controller.
package serial_addsub_ctrl_pkg;

  // Controller sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operation encoding on the op input
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_nibble_addsub.sv
// Combinational 4-bit ripple adder built from four full-adder cells.
module nibble_addsub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[4];

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Serial W-bit add/subtract: one nibble per clock, LSB first, through a
// single shared 4-bit slice. Subtract is A + ~B + 1 with the +1 entering as
// the initial carry.
module serial_addsub_ctrl
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   overflow
);

  localparam int unsigned W = 4 * NIBBLES;
  localparam logic [2:0]  LastIdx = 3'(NIBBLES - 1);

  state_t         state;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           op_q;
  logic [2:0]     idx;
  logic           carry;

  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic [3:0]     a_nib;
  logic [3:0]     b_nib;
  logic [3:0]     sum_nib;
  logic           slice_cout;
  logic           ovf_final;

  // Select the current nibble of each latched operand; invert B for subtract
  always_comb begin
    a_sh  = a_q >> {idx, 2'b00};
    b_sh  = b_q >> {idx, 2'b00};
    a_nib = a_sh[3:0];
    b_nib = b_sh[3:0] ^ {4{op_q}};
    // On the last nibble sum_nib[3] is the result MSB
    ovf_final = (a_q[W-1] == (b_q[W-1] ^ op_q)) && (sum_nib[3] != a_q[W-1]);
  end

  nibble_addsub u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .s    (sum_nib),
    .cout (slice_cout)
  );

  // Controller FSM with registered status and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      idx      <= '0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            idx   <= '0;
            carry <= op;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          result[int'(idx)*4 +: 4] <= sum_nib;
          carry                    <= slice_cout;
          if (idx == LastIdx) begin
            cout     <= slice_cout;
            overflow <= ovf_final;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed self-checking bench for serial_addsub_ctrl with NIBBLES = 4.
module tb_serial_addsub_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        overflow;

  int vectors;
  int miscompares;

  serial_addsub_ctrl #(.NIBBLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge, then wait (bounded) for done; lat = edges from
  // the start edge to the done edge, or -1 on timeout. Returns #1 after done.
  task automatic run_op(input logic o, input logic [15:0] x, input logic [15:0] y,
                        output int lat);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, cout, overflow} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 0000", {busy, done, cout, overflow});
    end
    vectors++;
    if (result !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_result got %h want 0000", result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_arith(input string name, input logic o, input logic [15:0] x,
                            input logic [15:0] y, input logic [15:0] exp_r,
                            input logic exp_c, input logic exp_v);
    int lat;
    run_op(o, x, y, lat);
    vectors++;
    if (lat !== 4) begin
      miscompares++;
      $display("FAIL %s_latency got %0d want 4", name, lat);
    end
    vectors++;
    if ({result, cout, overflow, busy} !== {exp_r, exp_c, exp_v, 1'b1}) begin
      miscompares++;
      $display("FAIL %s_result got r=%h c=%b v=%b busy=%b want r=%h c=%b v=%b busy=1",
               name, result, cout, overflow, busy, exp_r, exp_c, exp_v);
    end
    @(posedge clk); #1;
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s_idle got busy=%b done=%b want 0 0", name, busy, done);
    end
    vectors++;
    if ({result, cout, overflow} !== {exp_r, exp_c, exp_v}) begin
      miscompares++;
      $display("FAIL %s_hold got r=%h c=%b v=%b want r=%h c=%b v=%b",
               name, result, cout, overflow, exp_r, exp_c, exp_v);
    end
  endtask

  task automatic test_ignore_start();
    int ndone;
    int done_edge;
    logic [15:0] r_at_done;
    ndone = 0; done_edge = -1; r_at_done = '0;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'h1111; b = 16'h2222;
    @(posedge clk); #1;
    // Keep start high with different operands through RUN and DONE
    op = 1'b1; a = 16'hFFFF; b = 16'h1234;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++; done_edge = k; r_at_done = result;
      end
    end
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    vectors++;
    if (ndone !== 1 || done_edge !== 4) begin
      miscompares++;
      $display("FAIL ignore_done got count=%0d edge=%0d want count=1 edge=4", ndone, done_edge);
    end
    vectors++;
    if (r_at_done !== 16'h3333 || result !== 16'h3333 || cout !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_result got r@done=%h r=%h c=%b busy=%b want 3333 3333 0 0",
               r_at_done, result, cout, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    ndone = 0;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h0FFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({busy, done, cout, overflow} !== 4'b0000 || result !== 16'h0000) begin
      miscompares++;
      $display("FAIL midrst_clear got busy=%b done=%b c=%b v=%b r=%h want all 0",
               busy, done, cout, overflow, result);
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    vectors++;
    if (ndone !== 0) begin
      miscompares++;
      $display("FAIL midrst_nodone got %0d pulses want 0", ndone);
    end
    test_arith("midrst_add", 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic exp_d;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'h0101; b = 16'h0202;
    @(posedge clk); #1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      exp_d = (k % 6) == 4;
      vectors++;
      if (done !== exp_d) begin
        miscompares++;
        $display("FAIL b2b_done_edge%0d got %b want %b", k, done, exp_d);
      end
      if (exp_d) begin
        vectors++;
        if (result !== 16'h0303) begin
          miscompares++;
          $display("FAIL b2b_result_edge%0d got %h want 0303", k, result);
        end
      end
    end
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain got busy=%b want 0", busy);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_arith("add_1234_0fff", 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0);
    test_arith("sub_0005_0007", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    test_arith("sub_8000_0001", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
    test_arith("add_7fff_0001", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    test_arith("add_ffff_0001", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4, SHALL set operand width W = 4*NIBBLES bits; legal range 2..8.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  1  0 = add (A+B), 1 = subtract (A-B); sampled with start.
REQ-006 a  input  W  operand A; sampled with start.
REQ-007 b  input  W  operand B; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-009 done  output  1  one-cycle pulse; result/cout/overflow are valid and stable from this cycle on.
REQ-010 result  output  W  sum or difference, modulo 2^W.
REQ-011 cout  output  1  final carry out; for subtract, 1 = no borrow (A >= B unsigned).
REQ-012 overflow  output  1  two's-complement signed overflow of the completed operation.

Function
REQ-013 The block SHALL compute W-bit add/subtract serially, one 4-bit nibble per clock, LSB nibble first, through one shared 4-bit add/sub slice.
REQ-014 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after nibble NIBBLES-1 is processed; DONE->IDLE unconditionally after one cycle.
REQ-015 On the edge sampling start in IDLE, a, b, op SHALL be latched, nibble index cleared, carry register loaded with op.
REQ-016 Each RUN cycle SHALL apply A nibble, B nibble XOR {4{op}}, and carry register to the slice; write the sum nibble into result at the current index; store slice carry out; increment index.
REQ-017 done SHALL be high for exactly one cycle, NIBBLES clock edges after the edge that sampled start; busy SHALL be high from the edge after start through the done cycle.
REQ-018 cout SHALL equal the slice carry out of the final nibble.
REQ-019 overflow SHALL be 1 iff A[W-1] equals effective B[W-1] (B[W-1] XOR op) and result[W-1] differs from A[W-1].
REQ-020 start while busy SHALL be ignored, with no effect on the latched operands or progress.
REQ-021 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted (back-to-back throughput one op per NIBBLES+2 cycles).
REQ-022 result, cout, overflow SHALL hold their last completed values in IDLE until the next accepted start; during RUN result shows partially written nibbles and SHALL only be considered valid with or after done.
REQ-023 Nibble index SHALL never exceed NIBBLES-1; no wrap into a second pass.

Reset
REQ-024 rst high SHALL force state IDLE, nibble index 0, carry 0, busy 0, done 0, result 0, cout 0, overflow 0 on the next edge.
REQ-025 rst asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; start is accepted on the first edge with rst low.
REQ-026 rst SHALL take priority over start on the same edge.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE, RUN, DONE) and op encoding constants OP_ADD = 0, OP_SUB = 1.
REQ-028 One sub-module, nibble_addsub (combinational 4-bit ripple adder of four full-adder cells: inputs a[3:0], b[3:0], cin; outputs s[3:0], cout), SHALL be instantiated once; the B inversion is done in the controller.

Verification (NIBBLES = 4)
REQ-029 add 0x1234 + 0x0FFF -> result 0x2233, cout 0, overflow 0; done exactly 4 edges after start edge.
REQ-030 sub 0x0005 - 0x0007 -> result 0xFFFE, cout 0, overflow 0; sub 0x8000 - 0x0001 -> 0x7FFF, cout 1, overflow 1.
REQ-031 add 0x7FFF + 0x0001 -> 0x8000, cout 0, overflow 1; add 0xFFFF + 0x0001 -> 0x0000, cout 1, overflow 0.
REQ-032 start with new operands during RUN and in the DONE cycle -> ignored; first result unchanged; exactly one done pulse.
REQ-033 rst for one cycle after the 2nd RUN nibble -> all outputs 0 next edge, no done; subsequent add 0x0001 + 0x0001 -> 0x0002 with normal latency.
REQ-034 back-to-back: start held high continuously -> ops accepted every 6 cycles; each done pulse one cycle wide.
